uart_rx: RTL

Receive half of the FPGA board-to-board UART link. The block takes the asynchronous serial line, synchronises it and detects start bits. It samples each bit at its centre using a 3-sample majority vote, and delivers one 8-bit byte per frame with parity and framing status. Frame format is start(0), 8 data bits LSB first, one parity bit, one stop(1), which is the format `uart_tx` sends. The block sits between the board input pin and the command/data parsers.

---
 rtl/uart_rx_pkg.sv | 44 ++++
 rtl/uart_rx_sync.sv | 45 ++++
 rtl/uart_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART frame definitions used by the receive path:
//   - frame geometry (data bits, total bits per frame)
//   - parity-mode encodings
//   - bit-period derivation and small combinational helpers
//   - receiver FSM state encodings
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    // Frame geometry: start + 8 data + parity + stop.
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;

    // Parity-mode encodings for the PARITY parameter.
    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Receiver FSM states.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PAR       = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // System clocks per serial bit; must be at least 4 so that the
    // centre sample and both neighbours fall inside one bit period.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Parity bit the transmitter attaches for the given mode.
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                        input int mode);
        return (mode == PARITY_EVEN) ? ^data : ~^data;
    endfunction

    // 2-of-3 majority.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line followed by a
// two-deep history of the synchronised line, giving a 3-tap majority vote
// centred one cycle in the past.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset (all flops preset to idle-high)
//   rx    : raw serial line, asynchronous to clk
//   rx_s  : synchronised line (2 cycles after the pin)
//   vote  : majority of rx_s now, one cycle ago and two cycles ago
// -----------------------------------------------------------------------------
module uart_rx_sync
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic vote
);

    logic       meta;
    logic [1:0] taps;   // taps[0] = rx_s one cycle ago, taps[1] = two cycles ago

    // NOTE: every flop here is preset to 1 so a reset looks like an idle line
    // and can never be mistaken for a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            taps <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments let the chain shift one stage
            // per clock regardless of statement order.
            meta <= rx;
            rx_s <= meta;
            taps <= {taps[0], rx_s};
        end
    end

    // Evaluated in the cycle after the bit centre, so taps[0] is the centre.
    assign vote = majority3(rx_s, taps[0], taps[1]);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start(0), 8 data bits LSB first, parity, stop(1).
// Each bit is decided by a 3-sample majority around its centre; every frame
// is delivered with parity and framing status, errored frames included.
// Parameters:
//   CLK_FREQ  : system clock in Hz
//   BAUD_RATE : line bit rate (CLK_FREQ/BAUD_RATE >= 4)
//   PARITY    : 0 = even (parity = ^data), 1 = odd (parity = ~^data)
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   rx         : serial line, idle high, asynchronous
//   data_rx    : last received byte, held until the next rx_valid
//   rx_valid   : one-cycle pulse per completed frame
//   parity_err : parity mismatch for the frame flagged by rx_valid
//   frame_err  : stop bit sampled low for the frame flagged by rx_valid
//   rx_busy    : high from start detect until the frame ends
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ  = 60000000,
    parameter int BAUD_RATE = 6000000,
    parameter int PARITY    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_rx,
    output logic                      rx_valid,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    // The counter restarts at 0 the cycle after start detect, so the start
    // bit is decided at count HALF (centre + 1). Later bits are one full
    // period apart, the counter restarting after every decision.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    logic                      vote;
    logic [2:0]                state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      par_err_q;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s),
        .vote  (vote)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_err_q  <= 1'b0;
            data_rx    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            cnt      <= cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state   <= ST_START;
                        rx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (vote) begin
                            // Glitch shorter than half a bit: abandon silently.
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        shreg   <= {vote, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_PAR;
                        end
                    end
                end

                ST_PAR: begin
                    if (cnt == LAST_CNT) begin
                        cnt       <= '0;
                        par_err_q <= (vote != parity_bit(shreg, PARITY));
                        state     <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt        <= '0;
                        data_rx    <= shreg;
                        parity_err <= par_err_q;
                        frame_err  <= ~vote;
                        rx_valid   <= 1'b1;
                        rx_busy    <= 1'b0;
                        // A low stop bit may be the start of a break; hold
                        // off start detection until the line goes high.
                        state      <= vote ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end

                ST_WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
